// File: rtl/rv32i_ex_top.sv
// RV32I execute stage: ALU / address generation, branch resolution with a
// registered redirect, and a squash counter that bubbles younger instructions.
module rv32i_ex_top #(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic [31:0] rs2_data_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        br_taken,
    output logic [31:0] br_target
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [1:0] SQ_LOAD    = 2'(SQUASH_DEPTH);
    localparam logic [31:0] NOP_IW    = 32'h0000_0013;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] immI, immS, immB, immU, immJ;

    assign opcode = iw_in[6:0];
    assign funct3 = iw_in[14:12];
    assign immI   = {{20{iw_in[31]}}, iw_in[31:20]};
    assign immS   = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
    assign immB   = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
    assign immU   = {iw_in[31:12], 12'b0};
    assign immJ   = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

    // alt selects SUB on funct3=000 and SRA on funct3=101; ignored elsewhere.
    function automatic logic [31:0] aluOp(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    logic [31:0] alu_d, target_d;
    logic        taken, opValid, squashed;
    logic        wb_en_d, br_taken_d;
    logic [1:0]  squash_cnt_q, squash_cnt_d;

    always_comb begin
        alu_d    = '0;
        target_d = pc_in + immB;
        taken    = 1'b0;
        opValid  = 1'b1;
        case (opcode)
            OPC_OP:    alu_d = aluOp(funct3, iw_in[30], rs1_data_in, rs2_data_in);
            OPC_OPIMM: alu_d = aluOp(funct3, iw_in[30] && (funct3 == 3'b101), rs1_data_in, immI);
            OPC_LUI:   alu_d = immU;
            OPC_AUIPC: alu_d = pc_in + immU;
            OPC_JAL: begin
                alu_d    = pc_in + 32'd4;
                target_d = pc_in + immJ;
                taken    = 1'b1;
            end
            OPC_JALR: begin
                alu_d    = pc_in + 32'd4;
                target_d = (rs1_data_in + immI) & ~32'd1;
                taken    = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  taken = rs1_data_in == rs2_data_in;
                    3'b001:  taken = rs1_data_in != rs2_data_in;
                    3'b100:  taken = $signed(rs1_data_in) <  $signed(rs2_data_in);
                    3'b101:  taken = $signed(rs1_data_in) >= $signed(rs2_data_in);
                    3'b110:  taken = rs1_data_in <  rs2_data_in;
                    3'b111:  taken = rs1_data_in >= rs2_data_in;
                    default: taken = 1'b0;
                endcase
            end
            OPC_LOAD:  alu_d = rs1_data_in + immI;
            OPC_STORE: alu_d = rs1_data_in + immS;
            default:   opValid = 1'b0;
        endcase
    end

    // A squashed control transfer must neither redirect nor reload the counter.
    always_comb begin
        squashed     = squash_cnt_q != 2'd0;
        br_taken_d   = taken && !squashed;
        wb_en_d      = wb_en_in && opValid && (opcode != OPC_BRANCH) &&
                       (wb_reg_in != 5'd0) && !squashed;
        squash_cnt_d = 2'd0;
        if (squashed)
            squash_cnt_d = squash_cnt_q - 2'd1;
        else if (taken)
            squash_cnt_d = SQ_LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out       <= '0;
            iw_out       <= NOP_IW;
            alu_out      <= '0;
            rs2_data_out <= '0;
            wb_en_out    <= 1'b0;
            wb_reg_out   <= '0;
            br_taken     <= 1'b0;
            br_target    <= '0;
            squash_cnt_q <= '0;
        end else begin
            pc_out       <= pc_in;
            iw_out       <= iw_in;
            alu_out      <= alu_d;
            rs2_data_out <= rs2_data_in;
            wb_en_out    <= wb_en_d;
            wb_reg_out   <= wb_reg_in;
            br_taken     <= br_taken_d;
            br_target    <= target_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end
endmodule

// File: tb/tb_rv32i_ex_top.sv
// Self-checking bench for rv32i_ex_top: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_rv32i_ex_top;
    localparam int SQUASH_DEPTH = 2;
    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                           BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcIn, iwIn, rs1In, rs2In;
    logic        wbEnIn;
    logic [4:0]  wbRegIn;
    logic [31:0] pc_out, iw_out, alu_out, rs2_data_out, br_target;
    logic        wb_en_out, br_taken;
    logic [4:0]  wb_reg_out;

    int checks = 0;
    int errors = 0;
    int pending = 0;
    logic [31:0] expAlu, expTarget;
    logic        expWb, expTaken;

    rv32i_ex_top #(.SQUASH_DEPTH(SQUASH_DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_in(pcIn), .iw_in(iwIn),
        .rs1_data_in(rs1In), .rs2_data_in(rs2In), .wb_en_in(wbEnIn), .wb_reg_in(wbRegIn),
        .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out), .rs2_data_out(rs2_data_out),
        .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OP};
    endfunction
    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {imm, 5'd1, f3, rd, op};
    endfunction
    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], STORE};
    endfunction
    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], BRANCH};
    endfunction
    function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void refExec(input logic [31:0] pc, input logic [31:0] iw,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic valid,
                                    output logic taken, output logic [31:0] tgt);
        int sI, sS, sB, sJ;
        logic [2:0] f3;
        f3 = iw[14:12];
        sI = $signed(iw) >>> 20;
        sS = (($signed(iw) >>> 25) * 32) + int'(iw[11:7]);
        sB = (($signed(iw) >>> 31) * 4096) + int'(iw[7]) * 2048 + int'(iw[30:25]) * 32 + int'(iw[11:8]) * 2;
        sJ = (($signed(iw) >>> 31) * 1048576) + int'(iw[19:12]) * 4096 + int'(iw[20]) * 2048 + int'(iw[30:21]) * 2;
        res = 32'd0; valid = 1'b1; taken = 1'b0; tgt = 32'd0;
        case (iw[6:0])
            OP:     res = refAlu(f3, iw[30], a, b);
            OPIMM:  res = refAlu(f3, iw[30] && f3 == 3'd5, a, 32'(sI));
            LUI:    res = iw & 32'hFFFF_F000;
            AUIPC:  res = pc + (iw & 32'hFFFF_F000);
            JAL:    begin res = pc + 4; taken = 1'b1; tgt = pc + 32'(sJ); end
            JALR:   begin res = pc + 4; taken = 1'b1; tgt = (a + 32'(sI)) & 32'hFFFF_FFFE; end
            BRANCH: begin
                tgt = pc + 32'(sB);
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = !($signed(a) < $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = !(a < b);
                    default: taken = 1'b0;
                endcase
            end
            LOAD:   res = a + 32'(sI);
            STORE:  res = a + 32'(sS);
            default: valid = 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] a,
                         input logic [31:0] b, input logic wen, input logic [4:0] wreg);
        logic [31:0] res, tgt;
        logic valid, taken, sq;
        pcIn = pc; iwIn = iw; rs1In = a; rs2In = b; wbEnIn = wen; wbRegIn = wreg;
        refExec(pc, iw, a, b, res, valid, taken, tgt);
        sq = pending > 0;
        expAlu = res;
        expTarget = tgt;
        expTaken = taken && !sq;
        expWb = wen && valid && iw[6:0] != BRANCH && wreg != 5'd0 && !sq;
        if (sq) pending--;
        else if (taken) pending = SQUASH_DEPTH;
        @(posedge clk); #1;
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) issue(32'h900 + 32'(i * 4), 32'h0000_0013, 0, 0, 1'b0, 5'd0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        issue(32'h1234, encJ(21'd16, 5'd1), 32'h55, 32'hAA, 1'b1, 5'd9);
        @(posedge clk); #1;
        pending = 0;
        checks++; if (pc_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", pc_out); end
        checks++; if (iw_out !== 32'h13) begin errors++; $display("[TB] FAIL reset_iw got %h want 00000013", iw_out); end
        checks++; if (alu_out !== 32'd0 || rs2_data_out !== 32'd0 || br_target !== 32'd0)
            begin errors++; $display("[TB] FAIL reset_data got alu=%h rs2=%h tgt=%h want 0", alu_out, rs2_data_out, br_target); end
        checks++; if (wb_en_out !== 1'b0 || br_taken !== 1'b0 || wb_reg_out !== 5'd0)
            begin errors++; $display("[TB] FAIL reset_ctl got wb=%b br=%b reg=%0d want 0", wb_en_out, br_taken, wb_reg_out); end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        issue(32'h10, encR(7'd0, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd3);
        checks++; if (alu_out !== 32'h8000_0000 || wb_en_out !== 1'b1 || wb_reg_out !== 5'd3)
            begin errors++; $display("[TB] FAIL add got %h/%b/%0d want 80000000/1/3", alu_out, wb_en_out, wb_reg_out); end
        issue(32'h14, encR(7'h20, 3'd5, 5'd4), 32'h8000_0000, 32'd4, 1'b1, 5'd4);
        checks++; if (alu_out !== 32'hF800_0000) begin errors++; $display("[TB] FAIL sra got %h want f8000000", alu_out); end
        issue(32'h18, encR(7'd0, 3'd3, 5'd5), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd5);
        checks++; if (alu_out !== 32'd0) begin errors++; $display("[TB] FAIL sltu got %h want 0", alu_out); end
        issue(32'h1C, encR(7'd0, 3'd2, 5'd6), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6);
        checks++; if (alu_out !== 32'd1) begin errors++; $display("[TB] FAIL slt got %h want 1", alu_out); end
    endtask

    task automatic test_branch_squash;
        logic [2:0] wantWb;
        wantWb = 3'b100;
        issue(32'h100, encB(13'd16, 3'd0), 32'd5, 32'd5, 1'b0, 5'd0);
        checks++; if (br_taken !== 1'b1 || br_target !== 32'h110)
            begin errors++; $display("[TB] FAIL beq_redirect got %b/%h want 1/00000110", br_taken, br_target); end
        for (int i = 0; i < 3; i++) begin
            issue(32'h104 + 32'(i * 4), encI(12'd1, 3'd0, 5'd5, OPIMM), 32'd0, 32'd0, 1'b1, 5'd5);
            checks++; if (wb_en_out !== wantWb[i] || br_taken !== 1'b0)
                begin errors++; $display("[TB] FAIL squash_addi%0d got wb=%b br=%b want wb=%b br=0", i, wb_en_out, br_taken, wantWb[i]); end
        end
    endtask

    task automatic test_jump_in_window;
        issue(32'h300, encB(13'd8, 3'd1), 32'd1, 32'd2, 1'b0, 5'd0);
        checks++; if (br_taken !== 1'b1 || br_target !== 32'h308)
            begin errors++; $display("[TB] FAIL bne_redirect got %b/%h want 1/00000308", br_taken, br_target); end
        issue(32'h304, encJ(21'd64, 5'd1), 32'd0, 32'd0, 1'b1, 5'd1);
        checks++; if (br_taken !== 1'b0 || wb_en_out !== 1'b0)
            begin errors++; $display("[TB] FAIL jal_squashed got br=%b wb=%b want 0/0", br_taken, wb_en_out); end
        filler(2);
    endtask

    task automatic test_jalr;
        issue(32'h200, encI(12'd2, 3'd0, 5'd0, JALR), 32'h1001, 32'd0, 1'b1, 5'd0);
        checks++; if (br_taken !== 1'b1 || br_target !== 32'h1002 || alu_out !== 32'h204 || wb_en_out !== 1'b0)
            begin errors++; $display("[TB] FAIL jalr got br=%b tgt=%h alu=%h wb=%b want 1/00001002/00000204/0", br_taken, br_target, alu_out, wb_en_out); end
        filler(2);
    endtask

    task automatic test_store_unknown;
        issue(32'h40, encS(12'hFFC, 3'd2), 32'h1000, 32'hDEAD_BEEF, 1'b0, 5'd28);
        checks++; if (alu_out !== 32'h0FFC || wb_en_out !== 1'b0 || rs2_data_out !== 32'hDEAD_BEEF)
            begin errors++; $display("[TB] FAIL store got alu=%h wb=%b data=%h want 00000ffc/0/deadbeef", alu_out, wb_en_out, rs2_data_out); end
        issue(32'h44, 32'h0010_827F, 32'd3, 32'd4, 1'b1, 5'd4);
        checks++; if (wb_en_out !== 1'b0 || alu_out !== 32'd0 || br_taken !== 1'b0)
            begin errors++; $display("[TB] FAIL unknown_op got wb=%b alu=%h br=%b want 0/0/0", wb_en_out, alu_out, br_taken); end
    endtask

    task automatic test_reset_mid_squash;
        issue(32'h400, encB(13'd32, 3'd1), 32'd7, 32'd8, 1'b0, 5'd0);
        checks++; if (br_taken !== 1'b1) begin errors++; $display("[TB] FAIL rms_redirect got %b want 1", br_taken); end
        issue(32'h404, encI(12'd1, 3'd0, 5'd6, OPIMM), 32'd0, 32'd0, 1'b1, 5'd6);
        checks++; if (wb_en_out !== 1'b0) begin errors++; $display("[TB] FAIL rms_squashed got %b want 0", wb_en_out); end
        reset = 1'b1;
        issue(32'h408, encJ(21'd16, 5'd1), 32'd0, 32'd0, 1'b1, 5'd1);
        pending = 0;
        reset = 1'b0;
        checks++; if (br_taken !== 1'b0 || iw_out !== 32'h13)
            begin errors++; $display("[TB] FAIL rms_reset_priority got br=%b iw=%h want 0/00000013", br_taken, iw_out); end
        issue(32'h0, encI(12'd1, 3'd0, 5'd7, OPIMM), 32'd0, 32'd0, 1'b1, 5'd7);
        checks++; if (wb_en_out !== 1'b1 || alu_out !== 32'd1)
            begin errors++; $display("[TB] FAIL rms_post_reset got wb=%b alu=%h want 1/00000001", wb_en_out, alu_out); end
    endtask

    task automatic test_random;
        logic [31:0] iw, a, b, pc;
        logic [6:0] ops [11];
        ops = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, 7'h7F, 7'h0B};
        for (int i = 0; i < 400; i++) begin
            iw = $urandom; a = $urandom; b = $urandom; pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) != 0) iw[6:0] = ops[$urandom_range(0, 10)];
            if (iw[6:0] == BRANCH && iw[14:13] == 2'b01) iw[14] = 1'b1;
            if ($urandom_range(0, 2) == 0) b = a;
            issue(pc, iw, a, b, 1'($urandom), 5'($urandom));
            checks++; if (pc_out !== pcIn || iw_out !== iwIn || rs2_data_out !== rs2In || wb_reg_out !== wbRegIn)
                begin errors++; $display("[TB] FAIL rnd_pass%0d got pc=%h iw=%h d=%h r=%0d want %h %h %h %0d", i, pc_out, iw_out, rs2_data_out, wb_reg_out, pcIn, iwIn, rs2In, wbRegIn); end
            checks++; if (alu_out !== expAlu)
                begin errors++; $display("[TB] FAIL rnd_alu%0d iw=%h got %h want %h", i, iwIn, alu_out, expAlu); end
            checks++; if (wb_en_out !== expWb || br_taken !== expTaken)
                begin errors++; $display("[TB] FAIL rnd_ctl%0d iw=%h got wb=%b br=%b want wb=%b br=%b", i, iwIn, wb_en_out, br_taken, expWb, expTaken); end
            if (expTaken) begin
                checks++; if (br_target !== expTarget)
                    begin errors++; $display("[TB] FAIL rnd_tgt%0d iw=%h got %h want %h", i, iwIn, br_target, expTarget); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        pcIn = 0; iwIn = 32'h13; rs1In = 0; rs2In = 0; wbEnIn = 0; wbRegIn = 0;
        test_reset;
        test_alu;
        test_branch_squash;
        test_jump_in_window;
        test_jalr;
        test_store_unknown;
        test_reset_mid_squash;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_ex_top.md
# rv32i_ex_top

Execute stage of the RV32I pipeline, directly downstream of instruction decode and upstream of memory/writeback. It takes the decoded instruction word, PC and register operands and computes the ALU result or effective address. It resolves branches and jumps into a registered redirect, and squashes the younger in-flight instructions that follow a taken control transfer. All outputs are registered, so the stage has one cycle of latency.

## Interface
- SQUASH_DEPTH, 2: number of younger instructions invalidated after a taken branch or jump.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  32  PC of the instruction presented by decode.
- iw_in  in  32  instruction word from decode.
- rs1_data_in, rs2_data_in  in  32 each  operand values from decode.
- wb_en_in  in  1  writeback request from decode.
- wb_reg_in  in  5  destination register; aligned with iw_in.
- pc_out, iw_out  out  32 each  registered copies of the inputs, passed to the next stage.
- alu_out  out  32  result value, or load/store effective address.
- rs2_data_out  out  32  store data, registered.
- wb_en_out  out  1  qualified writeback enable.
- wb_reg_out  out  5  registered destination register.
- br_taken  out  1  redirect request to fetch; one-cycle pulse.
- br_target  out  32  redirect PC; valid only when br_taken is 1.

## Operation
- Immediates are formed from iw_in:
  - I: sign-extended [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All immediates are sign-extended to 32 bits.
- Opcode decode, iw_in[6:0]:
  - OP (0110011): funct3 selects ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. iw[30]=1 selects SUB and SRA.
  - OP-IMM (0010011): same operations with the I immediate. iw[30] is honoured only for SRLI/SRAI. ADDI ignores iw[30].
  - Shift amount is operand B[4:0]. SLT compares signed, SLTU compares unsigned. Both produce 0 or 1.
  - LUI: alu_out = U immediate.
  - AUIPC: alu_out = pc_in + U immediate.
  - JAL: alu_out = pc_in+4, target = pc_in + J immediate, taken.
  - JALR: alu_out = pc_in+4, target = (rs1 + I immediate) & ~1, taken.
  - BRANCH (1100011): funct3 selects BEQ/BNE/BLT/BGE/BLTU/BGEU. Target = pc_in + B immediate. alu_out = 0.
  - LOAD (0000011): alu_out = rs1 + I immediate.
  - STORE (0100011): alu_out = rs1 + S immediate.
  - Any other opcode: alu_out = 0, wb_en_out = 0, never taken.
- All arithmetic is modulo 2^32. Overflow and misaligned targets are not flagged.
- wb_en_out = wb_en_in AND opcode ≠ BRANCH AND opcode is valid AND wb_reg_in ≠ 0 AND not squashed.
- Squash logic:
  - A 2-bit counter, squash_cnt, tracks pending squashes.
  - When an un-squashed instruction is taken, the counter loads SQUASH_DEPTH in the same edge that asserts br_taken.
  - While squash_cnt ≠ 0, the incoming instruction is a bubble: wb_en_out=0 and br_taken=0. The counter decrements by 1 per cycle.
  - A squashed branch or jump never reloads the counter.
  - The counter has no saturation case; it only loads when it is 0.

## Timing
- One-cycle latency: inputs sampled at edge N appear on outputs after edge N.
- br_taken is high for exactly one cycle per un-squashed taken control transfer.
- Fetch redirects on the cycle that br_taken=1.
- The next SQUASH_DEPTH instructions accepted after that edge are squashed, one per clock. There is no stall input, so every clock accepts one instruction.
- Reset values:
  - pc_out, alu_out, rs2_data_out, br_target = 0.
  - iw_out = 32'h00000013 (NOP).
  - wb_reg_out = 0, wb_en_out = 0, br_taken = 0, squash_cnt = 0.
- Reset asserted mid-squash clears squash_cnt. The first instruction after reset deasserts is not squashed.
- Reset takes priority over everything, including a taken branch on the same edge.
- pc_out, iw_out and wb_reg_out pass through even for squashed instructions. Only wb_en_out and br_taken are suppressed.

## Test plan
- Reset: hold reset 2 cycles → every output at its reset value; iw_out = 0x00000013.
- ALU: ADD x3,x1,x2 with rs1=0x7FFFFFFF, rs2=1 → alu_out=0x80000000, wb_en_out=1, wb_reg_out=3.
  - SRA with rs1=0x80000000, shamt 4 → 0xF8000000.
  - SLTU with rs1=0xFFFFFFFF, rs2=1 → 0.
  - SLT with the same operands → 1.
- Branch squash: BEQ at pc=0x100, equal operands, imm=+16, followed by ADDI, ADDI, ADDI → br_taken=1 with br_target=0x110 for one cycle. The next two ADDIs have wb_en_out=0. The third has wb_en_out=1.
- Jump inside squash window: JAL immediately after a taken BNE → only the BNE redirect occurs; br_taken stays 0 for the JAL.
- JALR: pc=0x200, rs1=0x1001, imm=+2 → br_target=0x1002, alu_out=0x204. With wb_reg_in=0, wb_en_out=0.
- Store/unknown/reset-mid-squash:
  - SW with rs1=0x1000, S imm=−4 → alu_out=0x0FFC, wb_en_out=0.
  - Opcode 0x7F → wb_en_out=0.
  - Reset asserted one cycle after br_taken, with squash_cnt=1 → the first post-reset ADDI is written back.
